cronometro_multimodo: RTL and testbench
=======================================

// Module: cronometro_multimodo
// PURPOSE
//  Parametrised stopwatch/timer core: N_DIG decimal digits, each with its own 7-segment output.
//  Count modes: up (stopwatch) and down (timer, preset load).
//  Lap/freeze display while counting continues.
//  Replaces the fixed 4-digit button/counter/decoder chain at the top of the display path.
//  Buttons are raw board inputs; segments drive the board displays directly.
// PARAMETERS
//  N_DIG     4       number of BCD digits (1..8); digit 0 = least significant
//  TICK_DIV  500000  clk cycles per count step (>=2); 500000 = 100 Hz at 50 MHz
// PORTS
//  clk         in   1         single system clock, all logic on rising edge
//  rst         in   1         synchronous, active-high reset
//  btn_start   in   1         raw async button, active-high: start/pause
//  btn_clear   in   1         raw async button: clear/reload
//  btn_lap     in   1         raw async button: lap freeze toggle
//  btn_mode    in   1         raw async button: up/down mode toggle
//  preset_bcd  in   4*N_DIG   down-mode start value, digit i at [4i+3:4i]
//  seg         out  7*N_DIG   digit i at [7i+6:7i], order g..a (bit 7i = a), active-low
//  bcd         out  4*N_DIG   value currently shown (live count or frozen lap)
//  running     out  1         high in RUN
//  mode_down   out  1         0 = count up, 1 = count down
//  lap_active  out  1         display frozen
//  done        out  1         high while in DONE
//  overflow    out  1         one-cycle pulse on up-count wrap 99..9 -> 00..0
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=IDLE, count=0, mode_down=0, lap_active=0, prescaler=0
//   - sync/edge regs cleared
//   - bcd=0, seg shows "0" on all digits, running=done=overflow=0
//   - rst mid-RUN or mid-DONE behaves identically (no tick or pulse escapes)
//  Buttons:
//   - each passes a 2-FF synchroniser, then rising-edge detect -> 1-cycle press pulse
//   - registered state change on the 3rd clk edge that samples the button high
//   - held buttons act once
//  Press priority when pulses coincide: clear > start > lap > mode; lower presses that cycle are dropped.
//  FSM states IDLE, RUN, PAUSE, DONE:
//   - IDLE:
//     start -> RUN, except down mode with count=0 -> DONE
//     mode -> toggle mode_down; count loads 0 (up) or clamped preset (down)
//   - RUN:
//     start -> PAUSE
//     lap toggles lap_active
//     clear/mode ignored
//   - PAUSE:
//     start -> RUN
//     clear -> IDLE
//     lap -> lap_active=0
//   - DONE:
//     clear -> IDLE; all other presses ignored
//   - clear (where accepted): count=0 (up) or preset (down), lap_active=0, prescaler=0
//  Prescaler:
//   - counts 0..TICK_DIV-1 only in RUN; held (not cleared) in PAUSE; cleared in IDLE/DONE
//   - step occurs on the edge where prescaler==TICK_DIV-1 (prescaler -> 0)
//   - first step = TICK_DIV cycles after entering RUN from IDLE
//  Up step: BCD increment with ripple carry, each digit 0..9.
//   - all-9 -> all-0, overflow pulses the same edge, counting continues
//  Down step: BCD decrement with borrow.
//   - step reaching 0 -> DONE same edge, running drops, done rises
//   - count stays 0 in DONE
//  Preset load: any digit >9 is clamped to 9; preset is sampled only at load.
//  Display:
//   - lap_active=0: bcd = count, combinationally from the count register
//   - lap entering 1: bcd captures count at that edge and holds while count advances
//   - seg is a combinational decode of bcd; codes 0-9 only
// TESTING
//  TICK_DIV=4, N_DIG=4 for all scenarios.
//  1. rst; start press -> running=1 after 3 edges; after 40 cycles bcd=0010; start -> hold 0010; start resumes
//  2. Up wrap: start from 9998 (preload via force); 2 steps -> bcd=0000, overflow 1-cycle pulse exactly once
//  3. Down: mode in IDLE, preset=0003, start -> 0002,0001,0000 at 4-cycle steps; DONE, done=1; start ignored; clear -> 0003
//  4. Lap: RUN at 0005, lap -> bcd frozen 0005 while count runs; lap again -> bcd jumps to live count; pause clears freeze
//  5. Clear+start same cycle in PAUSE -> IDLE wins; rst mid-RUN -> all outputs reset values next edge; preset digit 0xC loads as 9

Source files
------------

// File: rtl/cronometro_multimodo.sv
// -----------------------------------------------------------------------------
// cronometro_multimodo
// Multi-mode stopwatch/timer core with N_DIG BCD digits and per-digit
// 7-segment outputs. Counts up (stopwatch) or down from a preset (timer).
// A lap function freezes the display while the count keeps running.
//
// Ports
//   clk          system clock, all logic on rising edge
//   rst          synchronous active-high reset
//   btn_start    raw button: start / pause
//   btn_clear    raw button: clear / reload
//   btn_lap      raw button: lap freeze toggle
//   btn_mode     raw button: up/down mode toggle (IDLE only)
//   preset_bcd   down-mode start value, digit i at [4i+3:4i]
//   seg          active-low segments, digit i at [7i+6:7i], bit 7i = a
//   bcd          displayed value (live count or frozen lap value)
//   running      high in RUN
//   mode_down    0 = count up, 1 = count down
//   lap_active   display frozen
//   done         high in DONE
//   overflow     one-cycle pulse on up-count wrap all-9 -> all-0
// -----------------------------------------------------------------------------
module cronometro_multimodo #(
    parameter int N_DIG    = 4,
    parameter int TICK_DIV = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_start,
    input  logic                 btn_clear,
    input  logic                 btn_lap,
    input  logic                 btn_mode,
    input  logic [4*N_DIG-1:0]   preset_bcd,
    output logic [7*N_DIG-1:0]   seg,
    output logic [4*N_DIG-1:0]   bcd,
    output logic                 running,
    output logic                 mode_down,
    output logic                 lap_active,
    output logic                 done,
    output logic                 overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = 4 * N_DIG;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Any preset digit above 9 is clamped to 9.
    function automatic logic [CW-1:0] clamp_preset(input logic [CW-1:0] p);
        logic [CW-1:0] r;
        r = p;
        for (int i = 0; i < N_DIG; i++) begin
            if (p[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = p[4*i +: 4];
            end
        end
        return r;
    endfunction

    // BCD increment with ripple carry; MSB of the result is the wrap carry.
    function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return {c, r};
    endfunction

    // BCD decrement with borrow; never applied to an all-zero count.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-low 7-segment decode, bit 0 = segment a; non-decimal codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   lap_bcd_q, lap_bcd_d;
    logic            mode_down_q, mode_down_d;
    logic            lap_active_q, lap_active_d;
    logic            overflow_q, overflow_d;
    logic [PW-1:0]   prescaler_q, prescaler_d;
    // Button vector bit order: 0 start, 1 clear, 2 lap, 3 mode
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      sync3_q, sync3_d;

    logic [3:0]      press_s;
    logic            tick_s;
    logic [CW:0]     inc_s;
    logic [CW-1:0]   dec_s;
    logic [CW-1:0]   reload_s;
    logic            reach_zero_s;

    // Button synchronisers and rising-edge detection.
    always_comb begin
        sync1_d = {btn_mode, btn_lap, btn_clear, btn_start};
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        press_s = sync2_q & ~sync3_q;
    end

    // Next-state, count, prescaler and lap logic.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_bcd_d    = lap_bcd_q;
        mode_down_d  = mode_down_q;
        lap_active_d = lap_active_q;
        overflow_d   = 1'b0;
        prescaler_d  = prescaler_q;
        tick_s       = (state_q == ST_RUN) && (prescaler_q == PW'(TICK_DIV - 1));
        inc_s        = bcd_inc(count_q);
        dec_s        = bcd_dec(count_q);
        reload_s     = mode_down_q ? clamp_preset(preset_bcd) : {CW{1'b0}};
        reach_zero_s = tick_s && mode_down_q && (dec_s == {CW{1'b0}});

        // Press handling follows clear > start > lap > mode; an if/else
        // chain drops the lower presses even when the winner is ignored.
        case (state_q)
            ST_IDLE: begin
                prescaler_d = {PW{1'b0}};
                if (press_s[1]) begin
                    count_d      = reload_s;
                    lap_active_d = 1'b0;
                end else if (press_s[0]) begin
                    if (mode_down_q && (count_q == {CW{1'b0}})) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (press_s[2]) begin
                    lap_active_d = lap_active_q;
                end else if (press_s[3]) begin
                    mode_down_d = ~mode_down_q;
                    count_d     = mode_down_q ? {CW{1'b0}} : clamp_preset(preset_bcd);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (tick_s) begin
                    prescaler_d = {PW{1'b0}};
                    if (mode_down_q) begin
                        count_d = dec_s;
                    end else begin
                        count_d    = inc_s[CW-1:0];
                        overflow_d = inc_s[CW];
                    end
                end else begin
                    prescaler_d = prescaler_q + PW'(1);
                end
                // Reaching zero ends the run even if a pause press coincides.
                if (reach_zero_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
                if (press_s[1]) begin
                    lap_active_d = lap_active_q;
                end else if (press_s[0]) begin
                    if (!reach_zero_s) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (press_s[2]) begin
                    lap_active_d = ~lap_active_q;
                    if (!lap_active_q) begin
                        lap_bcd_d = count_q;
                    end else begin
                        lap_bcd_d = lap_bcd_q;
                    end
                end else begin
                    lap_active_d = lap_active_q;
                end
            end
            ST_PAUSE: begin
                // Prescaler holds so a resume continues the partial interval.
                if (press_s[1]) begin
                    state_d      = ST_IDLE;
                    count_d      = reload_s;
                    lap_active_d = 1'b0;
                    prescaler_d  = {PW{1'b0}};
                end else if (press_s[0]) begin
                    state_d = ST_RUN;
                end else if (press_s[2]) begin
                    lap_active_d = 1'b0;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                prescaler_d = {PW{1'b0}};
                if (press_s[1]) begin
                    state_d      = ST_IDLE;
                    count_d      = reload_s;
                    lap_active_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                prescaler_d = {PW{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= {CW{1'b0}};
            lap_bcd_q    <= {CW{1'b0}};
            mode_down_q  <= 1'b0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            prescaler_q  <= {PW{1'b0}};
            sync1_q      <= 4'd0;
            sync2_q      <= 4'd0;
            sync3_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_bcd_q    <= lap_bcd_d;
            mode_down_q  <= mode_down_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            prescaler_q  <= prescaler_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
        end
    end

    // Display selection and per-digit segment decode.
    always_comb begin
        bcd = lap_active_q ? lap_bcd_q : count_q;
        seg = {(7*N_DIG){1'b1}};
        for (int i = 0; i < N_DIG; i++) begin
            seg[7*i +: 7] = seg_decode(bcd[4*i +: 4]);
        end
    end

    assign running    = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign mode_down  = mode_down_q;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cronometro_multimodo.sv
// -----------------------------------------------------------------------------
// tb_cronometro_multimodo
// Directed bench for cronometro_multimodo (N_DIG=4, TICK_DIV=4). Stimulus
// schedules expected outputs for absolute cycle numbers into a sorted
// queue; a monitor on the falling edge pops and compares them.
// Cycle number = count of rising edges so far.
// -----------------------------------------------------------------------------
module tb_cronometro_multimodo;

    localparam int K_BCD  = 0;
    localparam int K_RUN  = 1;
    localparam int K_DONE = 2;
    localparam int K_MODE = 3;
    localparam int K_LAP  = 4;
    localparam int K_OVF  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start, btn_clear, btn_lap, btn_mode;
    logic [15:0] preset_bcd;
    logic [27:0] seg;
    logic [15:0] bcd;
    logic        running, mode_down, lap_active, done, overflow;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    cronometro_multimodo #(.N_DIG(4), .TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .btn_lap    (btn_lap),
        .btn_mode   (btn_mode),
        .preset_bcd (preset_bcd),
        .seg        (seg),
        .bcd        (bcd),
        .running    (running),
        .mode_down  (mode_down),
        .lap_active (lap_active),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference segment patterns written active-high (gfedcba), then inverted.
    function automatic logic [27:0] seg_of(input logic [15:0] v);
        logic [27:0] r;
        logic [6:0]  p;
        r = 28'd0;
        for (int i = 0; i < 4; i++) begin
            case (v[4*i +: 4])
                4'd0:    p = 7'b0111111;
                4'd1:    p = 7'b0000110;
                4'd2:    p = 7'b1011011;
                4'd3:    p = 7'b1001111;
                4'd4:    p = 7'b1100110;
                4'd5:    p = 7'b1101101;
                4'd6:    p = 7'b1111101;
                4'd7:    p = 7'b0000111;
                4'd8:    p = 7'b1111111;
                4'd9:    p = 7'b1101111;
                default: p = 7'b0000000;
            endcase
            r[7*i +: 7] = ~p;
        end
        return r;
    endfunction

    task automatic expect_at(input int c, input int k, input logic [31:0] v);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, c, got, want);
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_BCD: begin
                    chk("bcd", e.cyc, {16'd0, bcd}, e.val);
                    chk("seg", e.cyc, {4'd0, seg}, {4'd0, seg_of(e.val[15:0])});
                end
                K_RUN:   chk("running", e.cyc, {31'd0, running}, e.val);
                K_DONE:  chk("done", e.cyc, {31'd0, done}, e.val);
                K_MODE:  chk("mode_down", e.cyc, {31'd0, mode_down}, e.val);
                K_LAP:   chk("lap_active", e.cyc, {31'd0, lap_active}, e.val);
                K_OVF:   chk("overflow", e.cyc, {31'd0, overflow}, e.val);
                default: chk("kind", e.cyc, 32'(e.kind), 32'd0);
            endcase
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold selected buttons (bit 0 start, 1 clear, 2 lap, 3 mode) for 4 edges.
    task automatic press(input logic [3:0] b);
        int c0;
        c0 = cyc;
        btn_start = b[0];
        btn_clear = b[1];
        btn_lap   = b[2];
        btn_mode  = b[3];
        goto(c0 + 4);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        btn_mode  = 1'b0;
    endtask

    task automatic expect_reset(input int c);
        expect_at(c, K_BCD, 32'h0);
        expect_at(c, K_RUN, 32'd0);
        expect_at(c, K_DONE, 32'd0);
        expect_at(c, K_MODE, 32'd0);
        expect_at(c, K_LAP, 32'd0);
        expect_at(c, K_OVF, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        btn_start  = 1'b0;
        btn_clear  = 1'b0;
        btn_lap    = 1'b0;
        btn_mode   = 1'b0;
        preset_bcd = 16'h0000;

        // 1. Reset, start, 10 steps, pause holds prescaler phase, resume.
        goto(2);
        rst = 1'b0;
        expect_reset(2);
        expect_at(4, K_RUN, 32'd0);
        expect_at(5, K_RUN, 32'd1);
        expect_at(8, K_BCD, 32'h0000);
        expect_at(9, K_BCD, 32'h0001);
        expect_at(44, K_BCD, 32'h0009);
        expect_at(45, K_BCD, 32'h0010);
        expect_at(47, K_RUN, 32'd1);
        expect_at(48, K_RUN, 32'd0);
        expect_at(48, K_BCD, 32'h0010);
        expect_at(60, K_BCD, 32'h0010);
        expect_at(63, K_RUN, 32'd1);
        expect_at(63, K_BCD, 32'h0010);
        expect_at(64, K_BCD, 32'h0011);
        press(4'b0001);
        goto(45);
        press(4'b0001);
        goto(60);
        press(4'b0001);

        // 2. Reset mid-RUN, preload 9998, wrap with single overflow pulse.
        goto(70);
        rst = 1'b1;
        goto(71);
        rst = 1'b0;
        expect_reset(71);
        goto(72);
        force dut.count_q = 16'h9998;
        goto(73);
        release dut.count_q;
        expect_at(73, K_BCD, 32'h9998);
        expect_at(74, K_BCD, 32'h9998);
        expect_at(81, K_BCD, 32'h9999);
        expect_at(85, K_BCD, 32'h0000);
        expect_at(89, K_BCD, 32'h0001);
        for (int c = 75; c <= 92; c++) begin
            expect_at(c, K_OVF, (c == 85) ? 32'd1 : 32'd0);
        end
        expect_at(95, K_RUN, 32'd0);
        expect_at(95, K_BCD, 32'h0002);
        expect_at(99, K_BCD, 32'h0000);
        expect_at(99, K_RUN, 32'd0);
        goto(74);
        press(4'b0001);
        goto(92);
        press(4'b0001);
        goto(96);
        press(4'b0010);

        // 3. Down mode from preset 0003 into DONE; start ignored; clear reloads.
        preset_bcd = 16'h0003;
        expect_at(102, K_MODE, 32'd0);
        expect_at(103, K_MODE, 32'd1);
        expect_at(103, K_BCD, 32'h0003);
        expect_at(111, K_BCD, 32'h0003);
        expect_at(112, K_BCD, 32'h0002);
        expect_at(116, K_BCD, 32'h0001);
        expect_at(119, K_DONE, 32'd0);
        expect_at(119, K_RUN, 32'd1);
        expect_at(120, K_DONE, 32'd1);
        expect_at(120, K_RUN, 32'd0);
        expect_at(120, K_BCD, 32'h0000);
        expect_at(126, K_DONE, 32'd1);
        expect_at(126, K_RUN, 32'd0);
        expect_at(126, K_BCD, 32'h0000);
        expect_at(130, K_DONE, 32'd1);
        expect_at(131, K_DONE, 32'd0);
        expect_at(131, K_BCD, 32'h0003);
        goto(100);
        press(4'b1000);
        goto(105);
        press(4'b0001);
        goto(122);
        press(4'b0001);
        goto(128);
        press(4'b0010);

        // 4. Lap freeze while counting, unfreeze, refreeze, clear in PAUSE.
        expect_at(136, K_MODE, 32'd0);
        expect_at(136, K_BCD, 32'h0000);
        expect_at(165, K_LAP, 32'd0);
        expect_at(166, K_LAP, 32'd1);
        expect_at(166, K_BCD, 32'h0005);
        expect_at(168, K_BCD, 32'h0005);
        expect_at(176, K_BCD, 32'h0005);
        expect_at(180, K_LAP, 32'd0);
        expect_at(180, K_BCD, 32'h0009);
        expect_at(188, K_LAP, 32'd1);
        expect_at(188, K_BCD, 32'h0011);
        expect_at(191, K_BCD, 32'h0011);
        expect_at(195, K_RUN, 32'd0);
        expect_at(195, K_BCD, 32'h0011);
        expect_at(200, K_BCD, 32'h0011);
        expect_at(201, K_LAP, 32'd0);
        expect_at(201, K_BCD, 32'h0013);
        goto(133);
        press(4'b1000);
        goto(140);
        press(4'b0001);
        goto(163);
        press(4'b0100);
        goto(177);
        press(4'b0100);
        goto(185);
        press(4'b0100);
        goto(192);
        press(4'b0001);
        goto(198);
        press(4'b0100);

        // 5. Clear+start in PAUSE -> IDLE; clamped preset; reset mid-RUN.
        expect_at(206, K_BCD, 32'h0013);
        expect_at(207, K_BCD, 32'h0000);
        expect_at(207, K_RUN, 32'd0);
        expect_at(210, K_RUN, 32'd0);
        expect_at(210, K_BCD, 32'h0000);
        expect_at(214, K_MODE, 32'd1);
        expect_at(214, K_BCD, 32'h0939);
        expect_at(217, K_BCD, 32'h0939);
        expect_at(224, K_BCD, 32'h0939);
        expect_at(225, K_BCD, 32'h0938);
        expect_at(225, K_RUN, 32'd1);
        expect_at(228, K_RUN, 32'd1);
        expect_reset(229);
        expect_at(233, K_BCD, 32'h0000);
        expect_at(233, K_RUN, 32'd0);
        goto(204);
        preset_bcd = 16'h0C3A;
        press(4'b0011);
        goto(211);
        press(4'b1000);
        goto(216);
        preset_bcd = 16'h1111;
        goto(218);
        press(4'b0001);
        goto(228);
        rst = 1'b1;
        goto(229);
        rst = 1'b0;

        goto(240);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL pending: %0d expectations never checked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
